imm_extend_unit: RTL and testbench

- Parametrised, registered immediate extender for the 16-bit datapath; successor to the fixed 8→16 combinational zero extender.
- Collects one or more IN_W-bit immediate fragments over a valid/ready stream and concatenates them.
- Applies zero, sign or high-place (LUI-style) extension to OUT_W and presents the result on a registered valid/ready output.
- Sits between instruction decode and the ALU B-operand mux.

---
 rtl/imm_extend_unit.sv | 140 ++++++++++++++
 tb/tb_imm_extend_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_unit.sv
// Registered immediate extender: gathers IN_W-bit fragments, then zero/sign/
// high-place extends the concatenation to OUT_W behind a valid/ready output.
module imm_extend_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int MAX_CHUNKS = OUT_W / IN_W;
  localparam int CW = $clog2(MAX_CHUNKS + 2);
  localparam int SW = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [OUT_W-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [OUT_W-1:0] r_out_data, w_out_data_nxt;
  logic             r_out_ovf, w_out_ovf_nxt;
  logic             r_out_err, w_out_err_nxt;

  logic             w_fire;
  logic             w_full;
  logic [CW-1:0]    w_n;
  logic [OUT_W-1:0] w_v;
  logic [OUT_W-1:0] w_mask;
  logic [OUT_W-1:0] w_zx;
  logic [OUT_W-1:0] w_ext;
  logic             w_sign;
  logic [SW-1:0]    w_sh;

  assign in_ready  = (r_state != S_HOLD) || out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_err   = r_out_err;

  assign w_fire = in_valid && in_ready;
  assign w_full = r_cnt >= CW'(MAX_CHUNKS);
  assign w_n    = w_full ? CW'(MAX_CHUNKS) : r_cnt + CW'(1);
  assign w_v    = (r_acc << IN_W) | OUT_W'(in_data);
  assign w_zx   = w_v & w_mask;

  // Field width is a whole number of fragments, so decode it per chunk.
  always_comb begin
    w_mask = '0;
    w_sign = 1'b0;
    w_sh   = '0;
    for (int i = 0; i < MAX_CHUNKS; i++) begin
      if (CW'(i) < w_n) w_mask[i*IN_W +: IN_W] = '1;
      if (CW'(i + 1) == w_n) begin
        w_sign = w_v[i*IN_W + IN_W - 1];
        w_sh   = SW'(OUT_W - (i + 1) * IN_W);
      end
    end
  end

  always_comb begin
    w_ext = w_zx;
    unique case (1'b1)
      (mode == 2'b01): w_ext = w_sign ? (w_zx | ~w_mask) : w_zx;
      (mode == 2'b10): w_ext = w_zx << w_sh;
      default:         w_ext = w_zx;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_ovf_nxt   = r_out_ovf;
    w_out_err_nxt   = r_out_err;
    if (r_state == S_HOLD && out_ready) begin
      w_out_valid_nxt = 1'b0;
      w_state_nxt     = S_IDLE;
    end
    if (w_fire) begin
      if (in_last) begin
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
        w_ovf_nxt       = 1'b0;
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_ext;
        w_out_ovf_nxt   = r_ovf | w_full;
        w_out_err_nxt   = (mode == 2'b11);
        w_state_nxt     = S_HOLD;
      end else begin
        w_acc_nxt   = w_v;
        w_cnt_nxt   = (r_cnt > CW'(MAX_CHUNKS)) ? r_cnt
                                                : r_cnt + CW'(1);
        w_ovf_nxt   = r_ovf | w_full;
        w_state_nxt = S_ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
      r_out_err   <= w_out_err_nxt;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Bench for imm_extend_unit: directed cases plus random traffic
// against a fragment-queue reference model.
module tb_imm_extend_unit;

  localparam int IW = 8;
  localparam int OW = 16;
  localparam int MX = OW / IW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_ovf;
  logic          out_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IW-1:0] frags[$];
  logic          m_valid = 1'b0;
  logic [OW-1:0] m_data  = '0;
  logic          m_ovf   = 1'b0;
  logic          m_err   = 1'b0;

  imm_extend_unit #(.IN_W(IW), .OUT_W(OW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result from the whole fragment list: concatenate, keep the low OW bits,
  // then extend from the field width (capped at OW).
  function automatic logic [OW-1:0] model_ext(input logic [IW-1:0] f[$],
                                              input logic [1:0] md);
    longint unsigned val;
    longint unsigned mask;
    longint unsigned full;
    int n;
    int w;
    full = (64'd1 << OW) - 1;
    val  = 0;
    foreach (f[i]) val = ((val << IW) | longint'(f[i])) & full;
    n    = (f.size() > MX) ? MX : f.size();
    w    = n * IW;
    mask = (64'd1 << w) - 1;
    case (md)
      2'd1: begin
        if (((val >> (w - 1)) & 1) == 1) val = val | (full & ~mask);
        else val = val & mask;
      end
      2'd2: val = ((val & mask) << (OW - w)) & full;
      default: val = val & mask;
    endcase
    return OW'(val);
  endfunction

  initial begin
    forever begin
      logic rdy;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        frags.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
      end else begin
        rdy = !m_valid || out_ready;
        if (m_valid && out_ready) m_valid = 1'b0;
        if (in_valid && rdy) begin
          frags.push_back(in_data);
          if (in_last) begin
            m_data  = model_ext(frags, mode);
            m_ovf   = frags.size() > MX;
            m_err   = (mode == 2'b11);
            m_valid = 1'b1;
            frags.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_ovf",   32'(out_ovf),   32'(m_ovf));
    check("out_err",   32'(out_err),   32'(m_err));
    check("in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] d, input logic last,
                      input logic [1:0] md);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = md;
    k = 0;
    @(negedge clk);
    while (!(!m_valid || out_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got stalled expected accept");
    end
    sync();
    in_valid = 1'b0;
    in_data  = IW'($urandom);
    in_last  = 1'($urandom);
    mode     = 2'($urandom);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    sync();
    out_ready = 1'b0;
  endtask

  task automatic expect_res(input string nm, input logic [OW-1:0] d,
                            input logic ovf, input logic err);
    @(negedge clk);
    check({nm, "_data"},  32'(out_data),  32'(d));
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_ovf"},   32'(out_ovf),   32'(ovf));
    check({nm, "_err"},   32'(out_err),   32'(err));
    check({nm, "_model"}, 32'(m_data),    32'(d));
    sync();
    consume();
  endtask

  logic [OW-1:0] single_exp[4];

  initial begin
    single_exp[0] = 16'h0085;
    single_exp[1] = 16'hFF85;
    single_exp[2] = 16'h8500;
    single_exp[3] = 16'h0085;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    in_last   = 1'b1;
    mode      = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    sync();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    sync();

    for (int md = 0; md < 4; md++) begin
      send(8'h85, 1'b1, 2'(md));
      expect_res("single", single_exp[md], 1'b0, md == 3);
    end

    send(8'h12, 1'b0, 2'b10);
    send(8'hF4, 1'b1, 2'b01);
    expect_res("two", 16'h12F4, 1'b0, 1'b0);

    send(8'h12, 1'b0, 2'b00);
    repeat (3) sync();
    send(8'hF4, 1'b1, 2'b01);
    expect_res("gap", 16'h12F4, 1'b0, 1'b0);

    send(8'hAA, 1'b0, 2'b00);
    send(8'hBB, 1'b0, 2'b00);
    send(8'hCC, 1'b1, 2'b00);
    expect_res("ovf", 16'hBBCC, 1'b1, 1'b0);

    send(8'h34, 1'b1, 2'b00);
    repeat (4) begin
      @(negedge clk);
      check("bp_data",  32'(out_data), 32'h0034);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    sync();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    in_last   = 1'b1;
    mode      = 2'b00;
    sync();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    expect_res("b2b", 16'h0001, 1'b0, 1'b0);

    send(8'h7F, 1'b0, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    sync();
    send(8'h03, 1'b1, 2'b01);
    expect_res("midrst", 16'h0003, 1'b0, 1'b0);

    repeat (1500) begin
      in_valid  = 1'($urandom);
      in_data   = IW'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sync();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) sync();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
